matdet_stream_loader: RTL

// Sequential front end for the combinational matdetN cores. Accepts matrix elements
// one per handshake and packs them into the flat matrix bus that drives the core.

---
 rtl/matdet_stream_loader_pkg.sv | 7 +
 rtl/matdet_stream_loader.sv | 97 +++++++++
 2 files changed

// File: rtl/matdet_stream_loader_pkg.sv
// mat_pkg: shared FSM state type and index-width helper for the matdet stream loader
package mat_pkg;
    typedef enum logic [1:0] {LOAD, SETTLE, OUTPUT} state_e;
    function automatic int idx_width(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction
endpackage

// File: rtl/matdet_stream_loader.sv
// matdet_stream_loader: packs streamed elements into a matdetN bus, settles, and returns the determinant
module matdet_stream_loader
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int MATRIX_SIZE   = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [DATA_WIDTH-1:0]                     in_data,
    input  logic                                      in_valid,
    input  logic                                      in_last,
    output logic                                      in_ready,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat,
    input  logic [DATA_WIDTH-1:0]                     core_det,
    output logic [DATA_WIDTH-1:0]                     out_det,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      frame_err
);
    localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IW = idx_width(MATRIX_SIZE);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int MW = NN * DATA_WIDTH;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MW-1:0]         mat_q, mat_d;
    logic [DATA_WIDTH-1:0] det_q, det_d;
    logic                  err_q, err_d;
    logic                  rdy_q;
    logic                  acc;

    assign acc       = in_valid && rdy_q && state_q == LOAD;
    assign in_ready  = rdy_q;
    assign mat       = mat_q;
    assign out_det   = det_q;
    assign out_valid = state_q == OUTPUT;
    assign frame_err = err_q;

    // next-state: element packing, settle countdown, result handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mat_d   = mat_q;
        det_d   = det_q;
        err_d   = err_q;
        case (state_q)
            LOAD: if (acc) begin
                mat_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = in_data;
                if (idx_q == IW'(NN - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
                    idx_d   = '0;
                    err_d   = err_q | ~in_last;
                end else if (in_last) begin
                    idx_d = '0;
                    err_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SETTLE: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                det_d   = core_det;
                state_d = OUTPUT;
            end
            OUTPUT: state_d = out_ready ? LOAD : OUTPUT;
            default: state_d = LOAD;
        endcase
    end

    // state and datapath registers; in_ready is registered so it rises on the first edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            mat_q   <= '0;
            det_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mat_q   <= mat_d;
            det_q   <= det_d;
            err_q   <= err_d;
            rdy_q   <= state_d == LOAD;
        end
    end
endmodule
